// File: rtl/fb_sched_pkg.sv
// Shared types and helpers for the frame-buffer slot scheduler.
package fb_sched_pkg;

    localparam int IDX_W     = 3;
    localparam int MAX_SLOTS = 1 << IDX_W;

    typedef enum logic [1:0] {
        FREE,
        WRITING,
        READY,
        READING
    } slot_state_t;

    typedef enum logic {
        W_IDLE,
        W_ACTIVE
    } wr_state_t;

    typedef enum logic [1:0] {
        R_EMPTY,
        R_WAIT,
        R_HOLD
    } rd_state_t;

    // Only ever called with constant arguments, so the multiply folds away at elaboration.
    function automatic logic [63:0] slot_base(input logic [63:0] start_addr,
                                              input int          idx,
                                              input logic [63:0] frame_size);
        return start_addr + 64'(idx) * frame_size;
    endfunction

endpackage

// File: rtl/fb_sat_cnt.sv
// Event counter that sticks at its maximum value instead of wrapping.
module fb_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fb_slot_scheduler.sv
// Triple-buffer slot scheduler: hands frame slots to the AXI writer and reader,
// keeping newest-complete-frame semantics with drop and repeat accounting.
module fb_slot_scheduler
    import fb_sched_pkg::*;
#(
    parameter logic [31:0] START_ADDR    = 32'h3fff0000,
    parameter int          FRAMES_AMOUNT = 3,
    parameter int          FRAME_RES_X   = 1920,
    parameter int          FRAME_RES_Y   = 1080,
    parameter int          PX_BYTES      = 2,
    parameter int          ADDR_WIDTH    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wr_req_i,
    input  logic                  wr_done_i,
    output logic                  wr_ack_o,
    output logic [ADDR_WIDTH-1:0] wr_base_addr_o,
    output logic [2:0]            wr_idx_o,
    input  logic                  rd_req_i,
    output logic                  rd_ack_o,
    output logic [ADDR_WIDTH-1:0] rd_base_addr_o,
    output logic [2:0]            rd_idx_o,
    output logic [15:0]           drop_cnt_o,
    output logic [15:0]           repeat_cnt_o
);

    localparam logic [63:0] FRAME_SIZE = 64'(FRAME_RES_X) * 64'(FRAME_RES_Y) * 64'(PX_BYTES);

    logic [ADDR_WIDTH-1:0] base_tab [MAX_SLOTS];

    for (genvar g = 0; g < MAX_SLOTS; g++) begin : g_base
        assign base_tab[g] = ADDR_WIDTH'(slot_base(64'(START_ADDR), g, FRAME_SIZE));
    end

    slot_state_t           slot_q [MAX_SLOTS];
    slot_state_t           slot_d [MAX_SLOTS];
    wr_state_t             wr_st_q, wr_st_d;
    rd_state_t             rd_st_q, rd_st_d;
    logic [IDX_W-1:0]      wr_slot_q, wr_slot_d;
    logic [IDX_W-1:0]      rd_slot_q, rd_slot_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  rd_ack_q, rd_ack_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  drop_inc, rep_inc;
    logic                  rdy_hit, free_hit;
    logic [IDX_W-1:0]      rdy_idx, free_idx, wr_pick;

    always_comb begin
        slot_d    = slot_q;
        wr_st_d   = wr_st_q;
        rd_st_d   = rd_st_q;
        wr_slot_d = wr_slot_q;
        rd_slot_d = rd_slot_q;
        wr_ack_d  = 1'b0;
        rd_ack_d  = 1'b0;
        drop_inc  = 1'b0;
        rep_inc   = 1'b0;
        rdy_hit   = 1'b0;
        rdy_idx   = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        wr_pick   = '0;

        // Completion first, so the finished frame is visible to a same-cycle read or grant.
        if (wr_done_i && (wr_st_q == W_ACTIVE)) begin
            for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                if (slot_d[i] == READY) begin
                    slot_d[i] = FREE;
                    drop_inc  = 1'b1;
                end
            end
            slot_d[wr_slot_q] = READY;
            wr_st_d           = W_IDLE;
        end

        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
            if (slot_d[i] == READY) begin
                rdy_hit = 1'b1;
                rdy_idx = IDX_W'(i);
            end
        end

        // A parked reader behaves as if it keeps requesting until a frame shows up.
        if (rd_req_i || (rd_st_q == R_WAIT)) begin
            if (rdy_hit) begin
                if (rd_st_q == R_HOLD) begin
                    slot_d[rd_slot_q] = FREE;
                end
                slot_d[rdy_idx] = READING;
                rd_slot_d       = rdy_idx;
                rd_ack_d        = 1'b1;
                rd_st_d         = R_HOLD;
            end else if (rd_st_q == R_HOLD) begin
                rd_ack_d = 1'b1;
                rep_inc  = 1'b1;
            end else begin
                rd_st_d = R_WAIT;
            end
        end

        if (wr_req_i) begin
            if (wr_st_d == W_ACTIVE) begin
                slot_d[wr_slot_q] = FREE;
                drop_inc          = 1'b1;
            end
            rdy_hit = 1'b0;
            rdy_idx = '0;
            for (int i = FRAMES_AMOUNT - 1; i >= 0; i--) begin
                if (slot_d[i] == FREE) begin
                    free_hit = 1'b1;
                    free_idx = IDX_W'(i);
                end
                if (slot_d[i] == READY) begin
                    rdy_hit = 1'b1;
                    rdy_idx = IDX_W'(i);
                end
            end
            if (free_hit) begin
                wr_pick = free_idx;
            end else begin
                wr_pick  = rdy_idx;
                drop_inc = rdy_hit;
            end
            slot_d[wr_pick] = WRITING;
            wr_slot_d       = wr_pick;
            wr_st_d         = W_ACTIVE;
            wr_ack_d        = 1'b1;
        end

        wr_addr_d = wr_ack_d ? base_tab[wr_slot_d] : wr_addr_q;
        rd_addr_d = rd_ack_d ? base_tab[rd_slot_d] : rd_addr_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < MAX_SLOTS; i++) begin
                slot_q[i] <= FREE;
            end
            wr_st_q   <= W_IDLE;
            rd_st_q   <= R_EMPTY;
            wr_slot_q <= '0;
            rd_slot_q <= '0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
        end else begin
            slot_q    <= slot_d;
            wr_st_q   <= wr_st_d;
            rd_st_q   <= rd_st_d;
            wr_slot_q <= wr_slot_d;
            rd_slot_q <= rd_slot_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    fb_sat_cnt #(.WIDTH(16)) u_drop_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (drop_inc),
        .cnt_o   (drop_cnt_o)
    );

    fb_sat_cnt #(.WIDTH(16)) u_repeat_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (rep_inc),
        .cnt_o   (repeat_cnt_o)
    );

    assign wr_ack_o       = wr_ack_q;
    assign wr_idx_o       = wr_slot_q;
    assign wr_base_addr_o = wr_addr_q;
    assign rd_ack_o       = rd_ack_q;
    assign rd_idx_o       = rd_slot_q;
    assign rd_base_addr_o = rd_addr_q;

endmodule

// File: tb/tb_fb_slot_scheduler.sv
// Bench for fb_slot_scheduler: 3-slot and 2-slot instances share stimulus, each
// checked against an ownership-level model, plus hand-computed literal expectations.
module tb_fb_slot_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wr_req, wr_done, rd_req;
    logic        wr_ack [2];
    logic        rd_ack [2];
    logic [31:0] wr_addr [2];
    logic [31:0] rd_addr [2];
    logic [2:0]  wr_idx [2];
    logic [2:0]  rd_idx [2];
    logic [15:0] drop [2];
    logic [15:0] rep [2];

    fb_slot_scheduler #(.FRAMES_AMOUNT(3)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n),
        .wr_req_i(wr_req), .wr_done_i(wr_done),
        .wr_ack_o(wr_ack[0]), .wr_base_addr_o(wr_addr[0]), .wr_idx_o(wr_idx[0]),
        .rd_req_i(rd_req),
        .rd_ack_o(rd_ack[0]), .rd_base_addr_o(rd_addr[0]), .rd_idx_o(rd_idx[0]),
        .drop_cnt_o(drop[0]), .repeat_cnt_o(rep[0])
    );

    fb_slot_scheduler #(.FRAMES_AMOUNT(2)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n),
        .wr_req_i(wr_req), .wr_done_i(wr_done),
        .wr_ack_o(wr_ack[1]), .wr_base_addr_o(wr_addr[1]), .wr_idx_o(wr_idx[1]),
        .rd_req_i(rd_req),
        .rd_ack_o(rd_ack[1]), .rd_base_addr_o(rd_addr[1]), .rd_idx_o(rd_idx[1]),
        .drop_cnt_o(drop[1]), .repeat_cnt_o(rep[1])
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: which slot the writer owns, which frame is waiting, which is on screen (-1 = none).
    int nslots [2] = '{3, 2};
    int m_wr [2];
    int m_rdy [2];
    int m_rd [2];
    bit m_wait [2];
    int m_drop [2];
    int m_rep [2];
    bit e_wack [2];
    bit e_rack [2];
    int e_widx [2];
    int e_ridx [2];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] exp_base(input int idx);
        return 32'(64'h3FFF0000 + 64'(idx) * 64'h3F4800);
    endfunction

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_wr[k] = -1; m_rdy[k] = -1; m_rd[k] = -1; m_wait[k] = 1'b0;
            m_drop[k] = 0; m_rep[k] = 0;
            e_wack[k] = 1'b0; e_rack[k] = 1'b0; e_widx[k] = 0; e_ridx[k] = 0;
        end
    endfunction

    function automatic void model_step(input int k, input bit wq, input bit wd, input bit rq);
        int pick;
        e_wack[k] = 1'b0;
        e_rack[k] = 1'b0;
        if (wd && m_wr[k] >= 0) begin
            if (m_rdy[k] >= 0) m_drop[k]++;
            m_rdy[k] = m_wr[k];
            m_wr[k]  = -1;
        end
        if (rq || m_wait[k]) begin
            if (m_rdy[k] >= 0) begin
                m_rd[k] = m_rdy[k]; m_rdy[k] = -1; m_wait[k] = 1'b0;
                e_rack[k] = 1'b1; e_ridx[k] = m_rd[k];
            end else if (m_rd[k] >= 0) begin
                m_rep[k]++;
                e_rack[k] = 1'b1; e_ridx[k] = m_rd[k];
            end else begin
                m_wait[k] = 1'b1;
            end
        end
        if (wq) begin
            pick = -1;
            if (m_wr[k] >= 0) begin
                m_drop[k]++;
                m_wr[k] = -1;
            end
            for (int i = 0; i < nslots[k]; i++)
                if (pick < 0 && i != m_rdy[k] && i != m_rd[k]) pick = i;
            if (pick < 0) begin
                pick = m_rdy[k]; m_rdy[k] = -1; m_drop[k]++;
            end
            m_wr[k] = pick;
            e_wack[k] = 1'b1; e_widx[k] = pick;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("wr_ack[%0d]", k), 64'(wr_ack[k]), 64'(e_wack[k]));
                chk($sformatf("rd_ack[%0d]", k), 64'(rd_ack[k]), 64'(e_rack[k]));
                chk($sformatf("drop[%0d]", k), 64'(drop[k]), 64'(sat(m_drop[k])));
                chk($sformatf("repeat[%0d]", k), 64'(rep[k]), 64'(sat(m_rep[k])));
                if (e_wack[k]) begin
                    chk($sformatf("wr_idx[%0d]", k), 64'(wr_idx[k]), 64'(e_widx[k]));
                    chk($sformatf("wr_addr[%0d]", k), 64'(wr_addr[k]), 64'(exp_base(e_widx[k])));
                    chk($sformatf("wr_on_reading[%0d]", k),
                        64'(int'(wr_idx[k]) == m_rd[k]), 64'(0));
                end
                if (e_rack[k]) begin
                    chk($sformatf("rd_idx[%0d]", k), 64'(rd_idx[k]), 64'(e_ridx[k]));
                    chk($sformatf("rd_addr[%0d]", k), 64'(rd_addr[k]), 64'(exp_base(e_ridx[k])));
                end
            end
        end
    end

    task automatic cyc(input bit wq, input bit wd, input bit rq);
        @(negedge clk);
        wr_req = wq; wr_done = wd; rd_req = rq;
        @(posedge clk);
        if (rst_n)
            for (int k = 0; k < 2; k++) model_step(k, wq, wd, rq);
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_wr_ack"}, 64'(wr_ack[k]), 64'(0));
            chk({tag, "_rd_ack"}, 64'(rd_ack[k]), 64'(0));
            chk({tag, "_wr_addr"}, 64'(wr_addr[k]), 64'(0));
            chk({tag, "_rd_idx"}, 64'(rd_idx[k]), 64'(0));
            chk({tag, "_drop"}, 64'(drop[k]), 64'(0));
            chk({tag, "_rep"}, 64'(rep[k]), 64'(0));
        end
    endtask

    int exp2 [4] = '{1, 0, 1, 0};

    initial begin
        rst_n = 1'b0; wr_req = 1'b0; wr_done = 1'b0; rd_req = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1; chk_en = 1'b1;

        // First grant goes to slot 0 at the base address, read follows it.
        cyc(1, 0, 0);
        #1 chk("t1_wr_ack", 64'(wr_ack[0]), 64'(1));
        chk("t1_wr_idx", 64'(wr_idx[0]), 64'(0));
        chk("t1_wr_addr", 64'(wr_addr[0]), 64'h3FFF0000);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        #1 chk("t1_rd_ack", 64'(rd_ack[0]), 64'(1));
        chk("t1_rd_idx", 64'(rd_idx[0]), 64'(0));

        // Balanced rates: writer alternates around the displayed slot.
        for (int it = 0; it < 4; it++) begin
            cyc(1, 0, 0);
            #1 chk($sformatf("t2_wr_idx%0d", it), 64'(wr_idx[0]), 64'(exp2[it]));
            cyc(0, 1, 0);
            cyc(0, 0, 1);
        end
        #1 chk("t2_drop", 64'(drop[0]), 64'(0));
        chk("t2_rep", 64'(rep[0]), 64'(0));

        // Writer twice as fast: one drop per pair of frames.
        for (int p = 0; p < 3; p++) begin
            cyc(1, 0, 0);
            cyc(0, 1, 0);
            cyc(1, 0, 0);
            if (p == 0) begin
                #1 chk("t3_wr_idx2", 64'(wr_idx[0]), 64'(2));
                chk("t3_wr_addr2", 64'(wr_addr[0]), 64'h407D9000);
            end
            cyc(0, 1, 0);
            cyc(0, 0, 1);
        end
        #1 chk("t3_drop", 64'(drop[0]), 64'(3));

        // Reader three times as fast: two repeats per frame.
        for (int f = 0; f < 2; f++) begin
            cyc(1, 0, 0);
            cyc(0, 1, 0);
            cyc(0, 0, 1);
            cyc(0, 0, 1);
            cyc(0, 0, 1);
        end
        #1 chk("t4_rep", 64'(rep[0]), 64'(4));
        chk("t4_rd_idx", 64'(rd_idx[0]), 64'(1));
        chk("t4_drop", 64'(drop[0]), 64'(3));

        // Asynchronous reset while a write ack is showing and the reader holds a slot.
        cyc(1, 0, 0);
        #1 chk("t6_pre_ack", 64'(wr_ack[0]), 64'(1));
        rst_n = 1'b0; wr_req = 1'b0; wr_done = 1'b0; rd_req = 1'b0;
        #1 chk_zero("t6_async");
        chk_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; chk_en = 1'b1;

        // Early read parks until the first completed frame.
        cyc(0, 0, 1);
        for (int w = 0; w < 3; w++) begin
            cyc(0, 0, 0);
            #1 chk($sformatf("t5_no_ack%0d", w), 64'(rd_ack[0]), 64'(0));
        end
        cyc(1, 0, 0);
        #1 chk("t6_first_idx", 64'(wr_idx[0]), 64'(0));
        chk("t5_no_ack_req", 64'(rd_ack[0]), 64'(0));
        cyc(0, 1, 0);
        #1 chk("t5_wait_ack", 64'(rd_ack[0]), 64'(1));
        chk("t5_wait_idx", 64'(rd_idx[0]), 64'(0));
        cyc(1, 0, 0);
        cyc(0, 1, 1);
        #1 chk("t5_bypass_ack", 64'(rd_ack[0]), 64'(1));
        chk("t5_bypass_idx", 64'(rd_idx[0]), 64'(1));
        chk("t5_bypass_idx_n2", 64'(rd_idx[1]), 64'(1));

        // Random traffic at shifting rates, including collisions and stray dones.
        for (int seg = 0; seg < 6; seg++) begin
            int pw, pd, pr;
            pw = 1 + (seg % 3);
            pd = 1 + ((seg + 1) % 3);
            pr = 1 + ((seg + 2) % 3);
            for (int n = 0; n < 500; n++) begin
                cyc($urandom_range(0, 7) < pw, $urandom_range(0, 7) < pd, $urandom_range(0, 7) < pr);
            end
        end
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
